// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner ids and the
// word returned when a memory access times out.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam logic [31:0] DMEM_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory bus signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(parameter int AW = 32);

  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [31:0]   cpu_wdata_i;
  logic [31:0]   cpu_rdata_o;
  logic          cpu_stall_o;

  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [31:0]   dbg_wdata_i;
  logic          dbg_gnt_o;
  logic          dbg_rvalid_o;
  logic [31:0]   dbg_rdata_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  logic          mem_ack_i;

  logic          err_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output err_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  err_o
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. The last-owner pointer starts at DBG so the
// CPU wins the first tie after reset.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_cpu,
  input  logic   req_dbg,
  input  logic   update,
  input  owner_t served,
  output logic   grant,
  output owner_t winner
);

  owner_t last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last <= OWN_DBG;
    else if (update) last <= served;
  end

  always_comb begin
    grant  = req_cpu | req_dbg;
    winner = OWN_CPU;
    if (req_cpu && req_dbg) begin
      if (last == OWN_DBG) winner = OWN_CPU;
      else                 winner = OWN_DBG;
    end else if (req_dbg) begin
      winner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences CPU and debug accesses onto a shared data memory with variable ack
// latency and a timeout watchdog. Define DMEM_ARB_PERF_EN for stall/conflict counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] conflict_cnt_o
`endif
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  state_t        state, state_nxt;
  owner_t        owner, winner;
  logic          grant, busy, timeout, stall;
  logic          we_q, err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, cpu_rdata_q, dbg_rdata_q;
  logic [CW-1:0] cnt;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_cpu(bus.cpu_req_i),
    .req_dbg(bus.dbg_req_i),
    .update (state == DONE),
    .served (owner),
    .grant  (grant),
    .winner (winner)
  );

  assign busy    = (state == BUSY);
  assign timeout = busy && !bus.mem_ack_i && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack_i || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lands straight in the per-owner output register so it is
  // visible during DONE and holds afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner <= winner;
          if (winner == OWN_DBG) begin
            we_q    <= bus.dbg_we_i;
            addr_q  <= bus.dbg_addr_i;
            wdata_q <= bus.dbg_wdata_i;
          end else begin
            we_q    <= bus.cpu_we_i;
            addr_q  <= bus.cpu_addr_i;
            wdata_q <= bus.cpu_wdata_i;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_ack_i) begin
            if (owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata_i;
            else                  dbg_rdata_q <= bus.mem_rdata_i;
          end else if (timeout) begin
            err_q <= 1'b1;
            if (owner == OWN_CPU) cpu_rdata_q <= DMEM_TIMEOUT_DATA;
            else                  dbg_rdata_q <= DMEM_TIMEOUT_DATA;
          end
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Reset also forces the stall and grant low so nothing leaks out while held.
  assign stall = bus.cpu_req_i && !rst_i && !((state == DONE) && (owner == OWN_CPU));

  assign bus.cpu_stall_o  = stall;
  assign bus.cpu_rdata_o  = cpu_rdata_q;
  assign bus.dbg_gnt_o    = !rst_i && (state == IDLE) && grant && (winner == OWN_DBG);
  assign bus.dbg_rvalid_o = (state == DONE) && (owner == OWN_DBG);
  assign bus.dbg_rdata_o  = dbg_rdata_q;
  assign bus.mem_req_o    = busy;
  assign bus.mem_we_o     = busy && we_q;
  assign bus.mem_addr_o   = busy ? (addr_q & WORD_MASK) : '0;
  assign bus.mem_wdata_o  = busy ? wdata_q : '0;
  assign bus.err_o        = err_q;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o    <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (stall && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if ((state == IDLE) && bus.cpu_req_i && bus.dbg_req_i &&
          (conflict_cnt_o != 32'hFFFF_FFFF))
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed CPU/debug accesses against a small
// memory model; monitors pop expected memory, CPU and debug responses from queues.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } cpu_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cpu_done_cyc = 0;
  int   dbg_gnt_cyc = 0;
  int   ack_delay = 0;
  bit   no_ack = 1'b0;

  mem_exp_t    mem_q[$];
  cpu_exp_t    cpu_q[$];
  logic [31:0] dbg_q[$];
  logic [31:0] mem_arr [0:63];

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt, conflict_cnt;
`endif

  dmem_arbiter_if #(.AW(32)) bus ();

  dmem_arbiter #(.AW(32), .TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef DMEM_ARB_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .conflict_cnt_o(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata_i = mem_arr[bus.mem_addr_o[7:2]];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Memory model: acks after ack_delay BUSY cycles; writes land after the ack edge.
  initial begin : responder
    bit          wr_pend;
    int          wr_idx;
    logic [31:0] wr_data;
    int          k;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_arr[0] = 32'h0000_0005;
    mem_arr[1] = 32'h0000_0011;
    mem_arr[2] = 32'hA5A5_0002;
    mem_arr[3] = 32'h0000_0033;
    mem_arr[5] = 32'h0000_0055;
    bus.mem_ack_i = 1'b0;
    wr_pend = 1'b0;
    wr_idx  = 0;
    wr_data = '0;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o && bus.mem_ack_i && bus.mem_we_o) begin
        wr_pend = 1'b1;
        wr_idx  = int'(bus.mem_addr_o[7:2]);
        wr_data = bus.mem_wdata_o;
      end
      @(posedge clk);
      #1;
      if (wr_pend) begin
        mem_arr[wr_idx] = wr_data;
        wr_pend = 1'b0;
      end
      if (bus.mem_req_o) begin
        bus.mem_ack_i = !no_ack && (k == ack_delay);
        k++;
      end else begin
        bus.mem_ack_i = 1'b0;
        k = 0;
      end
    end
  end

  initial begin : mem_monitor
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_o && bus.mem_ack_i) begin
        if (mem_q.size() == 0) checkOutput("mem_unexpected", 32'd1, 32'd0);
        else begin
          e = mem_q.pop_front();
          checkOutput("mem_we", {31'd0, bus.mem_we_o}, {31'd0, e.we});
          checkOutput("mem_addr", bus.mem_addr_o, e.addr);
          checkOutput("mem_wdata", bus.mem_wdata_o, e.wdata);
        end
      end
    end
  end

  initial begin : cpu_monitor
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.cpu_req_i && !bus.cpu_stall_o) begin
        cpu_done_cyc = cyc;
        if (cpu_q.size() == 0) checkOutput("cpu_unexpected", 32'd1, 32'd0);
        else begin
          e = cpu_q.pop_front();
          checkOutput("cpu_rdata", bus.cpu_rdata_o, e.data);
          checkOutput("cpu_err", {31'd0, bus.err_o}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin : dbg_monitor
    forever begin
      @(negedge clk);
      if (!rst && bus.dbg_gnt_o) dbg_gnt_cyc = cyc;
      if (!rst && bus.dbg_rvalid_o) begin
        if (dbg_q.size() == 0) checkOutput("dbg_unexpected", 32'd1, 32'd0);
        else checkOutput("dbg_rdata", bus.dbg_rdata_o, dbg_q.pop_front());
      end
    end
  end

  // CPU access: hold the request until the stall drops, counting busy cycles.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output int stall_cycles,
                               output int req_cycles, output int we_cycles);
    bit done;
    stall_cycles = 0;
    req_cycles   = 0;
    we_cycles    = 0;
    done         = 1'b0;
    @(posedge clk);
    #1;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mem_req_o) req_cycles++;
      if (bus.mem_req_o && bus.mem_we_o) we_cycles++;
      if (bus.cpu_stall_o) stall_cycles++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("cpu_access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
  endtask

  task automatic applyDbgStimulus(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    bus.dbg_req_i   = 1'b1;
    bus.dbg_we_i    = we;
    bus.dbg_addr_i  = addr;
    bus.dbg_wdata_i = wdata;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.dbg_gnt_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("dbg_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.dbg_req_i = 1'b0;
  endtask

  task automatic runTie(input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
                        input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                        output int cstall);
    int s, r, w;
    fork
      applyStimulus(cwe, caddr, cwdata, s, r, w);
      applyDbgStimulus(dwe, daddr, dwdata);
    join
    cstall = s;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int  s, r, w;
    bit  drained;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    checkOutput("rst_dbg_gnt", {31'd0, bus.dbg_gnt_o}, 32'd0);
    checkOutput("rst_dbg_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.err_o}, 32'd0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata_o, 32'd0);
    checkOutput("rst_dbg_rdata", bus.dbg_rdata_o, 32'd0);
    #1 rst = 1'b0;

    // Tie straight after reset: CPU first, then debug one cycle after CPU DONE.
    ack_delay = 0;
    mem_q.push_back('{1'b0, 32'h00, 32'h0});
    mem_q.push_back('{1'b0, 32'h08, 32'h0});
    cpu_q.push_back('{32'h5, 1'b0});
    dbg_q.push_back(32'hA5A5_0002);
    runTie(1'b0, 32'h00, 32'h0, 1'b0, 32'h08, 32'h0, s);
    checkOutput("tieA_cpu_stall", s, 2);
    checkOutput("tieA_gnt_after_cpu", dbg_gnt_cyc - cpu_done_cyc, 1);

    mem_q.push_back('{1'b1, 32'h0C, 32'h00C0_FFEE});
    mem_q.push_back('{1'b0, 32'h0C, 32'h0});
    cpu_q.push_back('{32'h33, 1'b0});
    dbg_q.push_back(32'h00C0_FFEE);
    runTie(1'b1, 32'h0C, 32'h00C0_FFEE, 1'b0, 32'h0C, 32'h0, s);
    checkOutput("tieB_cpu_stall", s, 2);
    checkOutput("tieB_gnt_after_cpu", dbg_gnt_cyc - cpu_done_cyc, 1);

    mem_q.push_back('{1'b0, 32'h00, 32'h0});
    cpu_q.push_back('{32'h5, 1'b0});
    applyStimulus(1'b0, 32'h00, 32'h0, s, r, w);
    checkOutput("lw0_stall", s, 2);
    checkOutput("lw0_req_cycles", r, 1);

    ack_delay = 2;
    mem_q.push_back('{1'b1, 32'h04, 32'h2A});
    cpu_q.push_back('{32'h11, 1'b0});
    applyStimulus(1'b1, 32'h06, 32'h2A, s, r, w);
    checkOutput("sw6_stall", s, 4);
    checkOutput("sw6_we_cycles", w, 3);

    ack_delay = 1;
    mem_q.push_back('{1'b0, 32'h04, 32'h0});
    cpu_q.push_back('{32'h2A, 1'b0});
    applyStimulus(1'b0, 32'h04, 32'h0, s, r, w);
    checkOutput("lw4_stall", s, 3);

    // CPU arrives one cycle behind a debug read and waits through it.
    ack_delay = 0;
    mem_q.push_back('{1'b0, 32'h14, 32'h0});
    mem_q.push_back('{1'b0, 32'h08, 32'h0});
    dbg_q.push_back(32'h55);
    cpu_q.push_back('{32'hA5A5_0002, 1'b0});
    fork
      applyDbgStimulus(1'b0, 32'h14, 32'h0);
      begin
        @(posedge clk);
        applyStimulus(1'b0, 32'h08, 32'h0, s, r, w);
      end
    join
    checkOutput("behind_dbg_stall", s, 4);
    repeat (2) @(negedge clk);

    no_ack = 1'b1;
    cpu_q.push_back('{32'hDEAD_BEEF, 1'b1});
    applyStimulus(1'b0, 32'h10, 32'h0, s, r, w);
    checkOutput("timeout_busy_cycles", r, 16);
    checkOutput("timeout_stall", s, 17);
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("err_sticky", {31'd0, bus.err_o}, 32'd1);

    // Flush: drop the request on the second BUSY cycle of a store.
    ack_delay = 3;
    mem_q.push_back('{1'b1, 32'h20, 32'h77});
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h20; bus.cpu_wdata_i = 32'h77;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    checkOutput("flush_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
    checkOutput("flush_mem_we", {31'd0, bus.mem_we_o}, 32'd1);
    drained = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.mem_req_o) begin
        drained = 1'b1;
        break;
      end
    end
    checkOutput("flush_drained", {31'd0, drained}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("err_still_set", {31'd0, bus.err_o}, 32'd1);

    // Asynchronous reset in the middle of BUSY.
    ack_delay = 10;
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h00; bus.cpu_wdata_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    checkOutput("async_rst_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    checkOutput("post_rst_err", {31'd0, bus.err_o}, 32'd0);

    ack_delay = 0;
    mem_q.push_back('{1'b0, 32'h14, 32'h0});
    mem_q.push_back('{1'b0, 32'h00, 32'h0});
    cpu_q.push_back('{32'h55, 1'b0});
    dbg_q.push_back(32'h5);
    runTie(1'b0, 32'h14, 32'h0, 1'b0, 32'h00, 32'h0, s);
    checkOutput("tieC_cpu_stall", s, 2);
    checkOutput("tieC_gnt_after_cpu", dbg_gnt_cyc - cpu_done_cyc, 1);
`ifdef DMEM_ARB_PERF_EN
    checkOutput("perf_stall_cnt", stall_cnt, 32'd2);
    checkOutput("perf_conflict_cnt", conflict_cnt, 32'd1);
`endif

    repeat (2) @(negedge clk);
    checkOutput("mem_q_drained", mem_q.size(), 0);
    checkOutput("cpu_q_drained", cpu_q.size(), 0);
    checkOutput("dbg_q_drained", dbg_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences all accesses to the shared Data_Memory and arbitrates between two requesters: the CPU MEM stage and a debug/loader port used by benches to preload or inspect memory.
- Holds the pipeline with cpu_stall_o while a CPU access is pending.
- Handles a memory with variable acknowledge latency, with a timeout watchdog.

Parameters:
- AW, 32: byte-address width.
- TIMEOUT, 16: cycles in BUSY without mem_ack_i before the access is aborted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cpu_req_i  in  1  MEM-stage access request; held stable while cpu_stall_o=1
- cpu_we_i  in  1  1=store (sw), 0=load (lw)
- cpu_addr_i  in  AW  byte address
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data; valid in the cycle cpu_stall_o falls
- cpu_stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- dbg_req_i  in  1  debug request; held until dbg_gnt_o
- dbg_we_i  in  1  debug write enable
- dbg_addr_i  in  AW  debug byte address
- dbg_wdata_i  in  32  debug write data
- dbg_gnt_o  out  1  one-cycle pulse when the debug request is latched
- dbg_rvalid_o  out  1  one-cycle pulse at completion
- dbg_rdata_o  out  32  read data, valid with dbg_rvalid_o
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  word-aligned address
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- mem_ack_i  in  1  access complete
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; every output 0; last-owner pointer = DBG, so the CPU wins the first tie; timeout counter 0.
- State IDLE:
  - If exactly one request is present, grant it.
  - If both are present, grant the requester not served last (round-robin).
  - Latch we, addr and wdata, set the owner, go to BUSY.
  - dbg_gnt_o pulses in the latching cycle when the owner is DBG.
- State BUSY:
  - mem_req_o=1, with mem_we_o/mem_addr_o/mem_wdata_o driven from the latched values.
  - mem_addr_o = {addr[AW-1:2], 2'b00}; byte offset discarded.
  - On mem_ack_i: capture mem_rdata_i, go to DONE.
  - Counter increments each BUSY cycle. When it reaches TIMEOUT-1 without ack: capture 32'hDEADBEEF, set err_o, go to DONE.
  - mem_ack_i in the same cycle as the timeout wins (normal completion).
- State DONE (one cycle):
  - Owner CPU: cpu_rdata_o = captured data.
  - Owner DBG: dbg_rvalid_o=1, dbg_rdata_o = captured data.
  - Update the last-owner pointer, clear the counter, go to IDLE.
  - A new request is not accepted in DONE.
- cpu_stall_o is combinational: cpu_req_i & ~(state==DONE & owner==CPU).
- Minimum CPU access with zero-wait ack is IDLE, BUSY, DONE: stall high for 2 cycles, low in the DONE cycle.
- CPU waiting behind a debug access: stall is held through the debug transaction plus its own.
- cpu_req_i dropped while owner=CPU (flush): the transaction still completes on the memory side. Writes are never aborted. Result is discarded and the stall deasserts immediately.
- cpu_req_i is sampled only in IDLE; the CPU must not change addr/we while stalled.
- rdata outputs hold their last value outside valid cycles.
- Async reset mid-BUSY drops mem_req_o immediately, so the memory must tolerate an abandoned request.
- err_o is cleared only by reset.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, adds outputs stall_cnt_o[31:0] and conflict_cnt_o[31:0], both reset to 0 and saturating at 32'hFFFFFFFF:
  - stall_cnt_o increments each cycle cpu_stall_o=1.
  - conflict_cnt_o increments in each IDLE cycle where both requests are present.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - owner encoding OWN_CPU=1'b0, OWN_DBG=1'b1;
  - constant DMEM_TIMEOUT_DATA=32'hDEADBEEF.
- One natural sub-module, rr_arb2: the two-requester round-robin picker with its last-owner pointer. Everything else stays in dmem_arbiter.

Test Plan:
- CPU lw addr 0x00, memory word 5, ack on the first BUSY cycle -> stall high 2 cycles; cpu_rdata_o=5 in DONE; mem_addr_o=0x00.
- CPU sw 0x0000002A to addr 0x06 with ack after 3 cycles -> mem_addr_o=0x04, mem_we_o=1 for 3 cycles; stall high 4 cycles; err_o=0.
- cpu_req_i and dbg_req_i both rise in the same cycle after reset -> CPU served first, DBG second (dbg_gnt_o in the cycle after CPU DONE); next simultaneous pair -> CPU first again (pointer=DBG).
- No ack with TIMEOUT=16 -> DONE after 16 BUSY cycles; cpu_rdata_o=32'hDEADBEEF; err_o=1 and stays 1.
- cpu_req_i dropped on the second BUSY cycle of a store -> store still issued until ack; cpu_stall_o=0 immediately; no CPU rdata consumed.
- rst_i pulsed mid-BUSY -> mem_req_o and cpu_stall_o drop within the same cycle; after release the CPU wins a tie. With DMEM_ARB_PERF_EN, the 2-cycle lw gives stall_cnt_o=2 and one tie gives conflict_cnt_o=1.
